// File: rtl/xor_descrambler64.sv
// ----------------------------------------------------------------------------
// xor_descrambler64
//
// Self-synchronizing descrambler for the polynomial 1 + x^39 + x^58, one
// WIDTH-bit word per clock. Each received bit is XORed with the received
// bits TAP_A and TAP_B positions earlier. The last TAP_B received bits are
// carried across words in a history register. There are valid/ready
// handshakes on both sides and a single registered output stage.
//
// Optional feature macro: XOR_DESCR_LOCK_EN
//   defined   - the first word after reset or flush only primes the history
//               and raises 'locked'; later words produce output.
//   undefined - every accepted word produces output and 'locked' is tied to 1.
// ----------------------------------------------------------------------------
module xor_descrambler64 #(
    parameter int WIDTH = 64,
    parameter int TAP_A = 39,
    parameter int TAP_B = 58
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             locked
);

    localparam int EXT_W = TAP_B + WIDTH;

    // Elaboration-time guards on the tap geometry.
    if (WIDTH < TAP_B) begin : g_bad_width
        $error("xor_descrambler64: WIDTH must be >= TAP_B");
    end
    if (TAP_A >= TAP_B || TAP_A < 1) begin : g_bad_taps
        $error("xor_descrambler64: need 1 <= TAP_A < TAP_B");
    end

    // History: hist_q[0] is the oldest received bit.
    logic [TAP_B-1:0] hist_q, hist_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             produce;
    logic [EXT_W-1:0] ext;
    logic [WIDTH-1:0] descr;

    // Ready is held low during reset and flush so no word can slip in then.
    assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Extended line: current word on top of the carried history, so bit
    // TAP_B+j is the current bit and bits j / TAP_B-TAP_A+j are its taps.
    assign ext   = {in_data, hist_q};
    assign descr = ext[TAP_B +: WIDTH]
                 ^ ext[TAP_B-TAP_A +: WIDTH]
                 ^ ext[0 +: WIDTH];

`ifdef XOR_DESCR_LOCK_EN
    logic locked_q, locked_d;

    // The priming word only loads history; output starts once locked.
    assign produce = accept && locked_q;
    assign locked  = locked_q;

    // Lock is lost on flush and gained on the first accept after it.
    always_comb begin
        locked_d = locked_q;
        if (flush) begin
            locked_d = 1'b0;
        end else if (accept) begin
            locked_d = 1'b1;
        end
    end

    // Lock flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end
`else
    // Zero history is treated as primed, so every word produces output.
    assign produce = accept;
    assign locked  = 1'b1;
`endif

    // Next-state for history and output stage; flush wins over any accept.
    always_comb begin
        // NOTE: every variable gets a default first so no path holds an old
        // value implicitly, which would infer a latch.
        hist_d      = hist_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            hist_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                hist_d = in_data[WIDTH-1 -: TAP_B];
            end
            if (produce) begin
                out_valid_d = 1'b1;
                out_data_d  = descr;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: out_data is cleared too, so a word pending at reset is
            // dropped rather than left visible on the bus.
            hist_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            hist_q      <= hist_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_xor_descrambler64.sv
// ----------------------------------------------------------------------------
// tb_xor_descrambler64
//
// Directed bench for xor_descrambler64. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge (or shortly after) so
// every observation is half a cycle away from the active edge. Builds with
// or without XOR_DESCR_LOCK_EN.
// ----------------------------------------------------------------------------
module tb_xor_descrambler64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        locked;

    int vectors     = 0;
    int miscompares = 0;

`ifdef XOR_DESCR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    // Value of 'locked' while in reset or just after flush.
    localparam logic LOCKED_IDLE = LOCK_EN ? 1'b0 : 1'b1;

    localparam logic [63:0] ONE_OUT  = 64'h0400_0080_0000_0001;
    localparam logic [63:0] ONES_OUT = 64'hFC00_007F_FFFF_FFFF;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // Serial reference scrambler state: sc_hist[57] is the newest bit.
    logic [57:0] sc_hist;

    xor_descrambler64 #(.WIDTH(64), .TAP_A(39), .TAP_B(58)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Bit-serial scrambler s = d ^ s[-39] ^ s[-58], bit 0 first on the line.
    task automatic scramble(input logic [63:0] d, output logic [63:0] s);
        for (int j = 0; j < 64; j++) begin
            s[j]    = d[j] ^ sc_hist[19] ^ sc_hist[0];
            sc_hist = {s[j], sc_hist[57:1]};
        end
    endtask

    // Short reset pulse, released on a falling edge.
    task automatic reset_dut();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        sc_hist   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // With locking enabled, feed one zero word to prime history (stays zero).
    task automatic prime();
`ifdef XOR_DESCR_LOCK_EN
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL prime_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL prime_locked got %b want 1", locked);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_out_data got %h want 0", out_data);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        vectors++;
        if (locked !== LOCKED_IDLE) begin
            miscompares++;
            $display("FAIL reset_locked got %b want %b", locked, LOCKED_IDLE);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        vectors++;
        if (locked !== LOCKED_IDLE) begin
            miscompares++;
            $display("FAIL release_locked got %b want %b", locked, LOCKED_IDLE);
        end
    endtask

    task automatic test_single_bit();
        reset_dut();
        prime();
        in_valid  = 1'b1;
        in_data   = 64'h1;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ONE_OUT) begin
            miscompares++;
            $display("FAIL single_bit got v=%b %h want v=1 %h", out_valid, out_data, ONE_OUT);
        end
        in_data = 64'h0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 64'h0) begin
            miscompares++;
            $display("FAIL single_bit_zero got v=%b %h want v=1 0", out_valid, out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_bit_drain got v=%b want 0", out_valid);
        end
    endtask

    // All-ones from zero history exercises every tap region of the word.
    task automatic test_all_ones();
        reset_dut();
        prime();
        in_valid  = 1'b1;
        in_data   = ALL_ONES;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_data !== ONES_OUT) begin
            miscompares++;
            $display("FAIL all_ones_first got %h want %h", out_data, ONES_OUT);
        end
        @(negedge clk);
        vectors++;
        if (out_data !== ALL_ONES) begin
            miscompares++;
            $display("FAIL all_ones_second got %h want %h", out_data, ALL_ONES);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        reset_dut();
        prime();
        in_valid  = 1'b1;
        in_data   = 64'h1;      // A
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ONE_OUT || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_capture_a got v=%b %h rdy=%b want v=1 %h rdy=0",
                     out_valid, out_data, in_ready, ONE_OUT);
        end
        in_data = ALL_ONES;     // B
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ONE_OUT || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold_a got v=%b %h rdy=%b want v=1 %h rdy=0",
                     out_valid, out_data, in_ready, ONE_OUT);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_pass got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ONES_OUT) begin
            miscompares++;
            $display("FAIL bp_take_b got v=%b %h want v=1 %h", out_valid, out_data, ONES_OUT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        reset_dut();
        prime();
        in_valid  = 1'b1;
        in_data   = ALL_ONES;   // leaves history all ones
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup got v=%b want 1", out_valid);
        end
        flush   = 1'b1;
        in_data = 64'h1234;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_in_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (locked !== LOCKED_IDLE) begin
            miscompares++;
            $display("FAIL flush_locked got %b want %b", locked, LOCKED_IDLE);
        end
        prime();
        in_valid  = 1'b1;
        in_data   = 64'h1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ONE_OUT) begin
            miscompares++;
            $display("FAIL flush_hist_clear got v=%b %h want v=1 %h", out_valid, out_data, ONE_OUT);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        reset_dut();
        prime();
        in_valid  = 1'b1;
        in_data   = ALL_ONES;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_setup got v=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_outputs got v=%b %h rdy=%b want v=0 0 rdy=0",
                     out_valid, out_data, in_ready);
        end
        vectors++;
        if (locked !== LOCKED_IDLE) begin
            miscompares++;
            $display("FAIL areset_locked got %b want %b", locked, LOCKED_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prime();
        in_valid  = 1'b1;
        in_data   = 64'h1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_data !== ONE_OUT) begin
            miscompares++;
            $display("FAIL areset_hist_lost got %h want %h", out_data, ONE_OUT);
        end
        @(negedge clk);
    endtask

    // Counting data through the scrambler model, one word per cycle.
    task automatic test_throughput();
        logic [63:0] s;
        reset_dut();
        prime();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            scramble(64'(k), s);
            in_valid = 1'b1;
            in_data  = s;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 64'(k)) begin
                miscompares++;
                $display("FAIL throughput[%0d] got v=%b %h want v=1 %h", k, out_valid, out_data, 64'(k));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL throughput_drain got v=%b want 0", out_valid);
        end
    endtask

    // Random words and random handshakes against the serial scrambler model.
    task automatic test_round_trip();
        logic [63:0] data_w [1000];
        logic [63:0] scr_w  [1000];
        logic [63:0] expq [$];
        logic [63:0] e;
        int  idx    = 0;
        int  cycles = 0;
        bit  skip   = LOCK_EN;
        bit  acc;
        bit  fire;
        reset_dut();
        for (int i = 0; i < 1000; i++) begin
            data_w[i] = {$urandom, $urandom};
            scramble(data_w[i], scr_w[i]);
        end
        while ((idx < 1000 || expq.size() > 0) && cycles < 20000) begin
            in_valid  = (idx < 1000) && ($urandom_range(0, 9) < 7);
            in_data   = (idx < 1000) ? scr_w[idx] : 64'h0;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL round_trip_extra got %h want no output", out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e) begin
                        miscompares++;
                        $display("FAIL round_trip got %h want %h", out_data, e);
                    end
                end
            end
            if (acc) begin
                if (skip) skip = 1'b0;
                else expq.push_back(data_w[idx]);
                idx++;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        vectors++;
        if (idx != 1000 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL round_trip_timeout got idx=%0d pending=%0d want 1000 0", idx, expq.size());
        end
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL round_trip_locked got %b want 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_all_ones();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_throughput();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
